// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter: request bundle and read-return tag.
package lisp;
  localparam int addr_width = 16;
  localparam int data_width = 16;
  localparam int max_req    = 4;
  localparam int port_w     = $clog2(max_req);

  typedef struct packed {
    logic                  we;
    logic [addr_width-1:0] addr;
    logic [data_width-1:0] wdata;
  } mem_req_t;

  // Sized for the largest supported requester count; upper bits stay 0 otherwise.
  typedef struct packed {
    logic              valid;
    logic [port_w-1:0] port_id;
  } mem_tag_t;
endpackage

// File: rtl/mem_arbiter_rr_arbiter.sv
// Round-robin grant logic: scans from rr_ptr, grants the first requester,
// and advances the pointer past the winner.
module rr_arbiter #(
  parameter  int NUM_REQ = 2,
  localparam int PW      = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_any,
  output logic [PW-1:0]      gnt_idx
);
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] sel;
  int            idx;

  always_comb begin
    gnt     = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    sel     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      sel = PW'(idx);
      if (en && !gnt_any && req[sel]) begin
        gnt[sel] = 1'b1;
        gnt_any  = 1'b1;
        gnt_idx  = sel;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          rr_ptr <= '0;
    else if (gnt_any) rr_ptr <= (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
  end
endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory controller port between NUM_REQ requesters with
// round-robin arbitration and a tag pipeline that routes read data back.
module mem_arbiter
  import lisp::*;
#(
  parameter  int NUM_REQ      = 2,
  parameter  int ADDR_WIDTH   = lisp::addr_width,
  parameter  int DATA_WIDTH   = lisp::data_width,
  parameter  int READ_LATENCY = 1,
  localparam int PW           = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          boot_done,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            rd_valid,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          busy,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic                          mem_we,
  output logic [DATA_WIDTH-1:0]         mem_wdata,
  input  logic [DATA_WIDTH-1:0]         mem_read_data
);
  mem_req_t                  reqs [NUM_REQ];
  mem_tag_t [READ_LATENCY:0] tag_pipe;
  mem_tag_t                  tag_in;
  mem_tag_t                  tag_out;
  logic                      gnt_any;
  logic [PW-1:0]             gnt_idx;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign reqs[i] = '{we:    req_we[i],
                       addr:  req_addr[i*ADDR_WIDTH +: ADDR_WIDTH],
                       wdata: req_wdata[i*DATA_WIDTH +: DATA_WIDTH]};
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk     (clk),
    .rst     (rst),
    .en      (boot_done),
    .req     (req),
    .gnt     (gnt),
    .gnt_any (gnt_any),
    .gnt_idx (gnt_idx)
  );

  // Only reads occupy the tag pipeline; writes and idle cycles shift in bubbles.
  assign tag_in = '{valid:   gnt_any && !reqs[gnt_idx].we,
                    port_id: port_w'(gnt_idx)};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      tag_pipe  <= '0;
    end else begin
      mem_we <= 1'b0;
      if (gnt_any) begin
        mem_addr  <= reqs[gnt_idx].addr;
        mem_we    <= reqs[gnt_idx].we;
        mem_wdata <= reqs[gnt_idx].wdata;
      end
      tag_pipe[0] <= tag_in;
      for (int k = 1; k <= READ_LATENCY; k++) tag_pipe[k] <= tag_pipe[k-1];
    end
  end

  assign tag_out = tag_pipe[READ_LATENCY];
  assign rd_data = tag_out.valid ? mem_read_data : '0;

  always_comb begin
    rd_valid = '0;
    if (tag_out.valid) rd_valid[tag_out.port_id[PW-1:0]] = 1'b1;
  end

  always_comb begin
    busy = 1'b0;
    for (int k = 0; k <= READ_LATENCY; k++) busy = busy | tag_pipe[k].valid;
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a one-cycle-latency memory stub.
module tb_mem_arbiter;
  localparam int N  = 2;
  localparam int AW = 16;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          boot_done;
  logic [N-1:0]  req, req_we, gnt, rd_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0] rd_data, mem_wdata, mem_read_data;
  logic [AW-1:0] mem_addr;
  logic          mem_we, busy;

  int n_assert = 0;
  int n_fail   = 0;
  int cnt0, cnt1;
  logic [N-1:0] exp_g [8];

  logic [DW-1:0] mem [256];

  always #5 clk = ~clk;

  mem_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(1)) dut (
    .clk(clk), .rst(rst), .boot_done(boot_done), .req(req), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .rd_valid(rd_valid),
    .rd_data(rd_data), .busy(busy), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_read_data(mem_read_data)
  );

  // Memory stub: preloaded on reset; word at 0x10 is 0x0001, others 0x12xx.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= (i == 16) ? 16'h0001 : {8'h12, 8'(i)};
      mem_read_data <= '0;
    end else begin
      if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
      mem_read_data <= mem[mem_addr[7:0]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_we[p] = we;
    req_addr[p*AW +: AW] = a;
    req_wdata[p*DW +: DW] = d;
  endtask

  initial begin
    rst = 1'b1; boot_done = 1'b0; req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    tick(); tick();
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_rdv", 32'(rd_valid), 0);
    chk("rst_rdd", 32'(rd_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_we", 32'(mem_we), 0);
    chk("rst_wd", 32'(mem_wdata), 0);
    rst = 1'b0;

    // Boot gating
    set_port(0, 1'b0, 16'h0010, 16'h0000);
    req = 2'b01;
    for (int c = 0; c < 5; c++) begin
      tick(); chk("boot_gate", 32'(gnt), 0);
    end
    tick(); boot_done = 1'b1; #1;
    chk("boot_gnt", 32'(gnt), 32'h1);
    tick(); req = '0; #1;
    chk("boot_addr", 32'(mem_addr), 32'h10);
    chk("boot_busy", 32'(busy), 1);
    tick();
    chk("boot_rdv", 32'(rd_valid), 32'h1);
    chk("boot_rdd", 32'(rd_data), 32'h0001);
    tick();
    chk("boot_rdv_end", 32'(rd_valid), 0);
    chk("boot_busy_end", 32'(busy), 0);

    // Write then read on port 1 (rr_ptr = 1)
    set_port(1, 1'b1, 16'h0020, 16'h00AB); req = 2'b10; #1;
    chk("wr_gnt", 32'(gnt), 32'h2);
    tick(); req = '0; #1;
    chk("wr_we", 32'(mem_we), 1);
    chk("wr_addr", 32'(mem_addr), 32'h20);
    chk("wr_data", 32'(mem_wdata), 32'hAB);
    chk("wr_busy", 32'(busy), 0);
    tick(); set_port(1, 1'b0, 16'h0020, 16'h0000); req = 2'b10; #1;
    chk("wr_we_pulse", 32'(mem_we), 0);
    chk("rd1_gnt", 32'(gnt), 32'h2);
    tick(); req = '0; #1;
    chk("rd1_we", 32'(mem_we), 0);
    tick();
    chk("rd1_rdv", 32'(rd_valid), 32'h2);
    chk("rd1_rdd", 32'(rd_data), 32'h00AB);

    // Contention fairness (rr_ptr = 0): alternating grants, reads pipelined
    set_port(0, 1'b0, 16'h0030, 16'h0); set_port(1, 1'b0, 16'h0031, 16'h0);
    cnt0 = 0; cnt1 = 0;
    for (int k = 0; k < 8; k++) exp_g[k] = (k % 2 == 0) ? 2'b01 : 2'b10;
    tick(); req = 2'b11; #1;
    for (int k = 0; k < 10; k++) begin
      if (k < 8) begin
        chk("fair_gnt", 32'(gnt), 32'(exp_g[k]));
        if (gnt[0]) cnt0++;
        if (gnt[1]) cnt1++;
      end
      if (k >= 2) begin
        chk("fair_rdv", 32'(rd_valid), 32'(exp_g[k-2]));
        chk("fair_rdd", 32'(rd_data), exp_g[k-2][0] ? 32'h1230 : 32'h1231);
      end
      tick();
      if (k == 7) req = '0;
      #1;
    end
    chk("fair_cnt0", 32'(cnt0), 4);
    chk("fair_cnt1", 32'(cnt1), 4);

    // Pipelined reads (rr_ptr = 0)
    req = 2'b01; #1;
    chk("pipe_gnt0", 32'(gnt), 32'h1);
    tick(); req = 2'b10; #1;
    chk("pipe_gnt1", 32'(gnt), 32'h2);
    chk("pipe_busy1", 32'(busy), 1);
    tick(); req = '0; #1;
    chk("pipe_rdv0", 32'(rd_valid), 32'h1);
    chk("pipe_rdd0", 32'(rd_data), 32'h1230);
    chk("pipe_busy2", 32'(busy), 1);
    tick();
    chk("pipe_rdv1", 32'(rd_valid), 32'h2);
    chk("pipe_rdd1", 32'(rd_data), 32'h1231);
    chk("pipe_busy3", 32'(busy), 1);
    tick();
    chk("pipe_busy4", 32'(busy), 0);
    chk("pipe_rdv_end", 32'(rd_valid), 0);

    // boot_done dropping: no new grants, in-flight read still returns
    set_port(0, 1'b0, 16'h0010, 16'h0); req = 2'b01; #1;
    chk("bd_gnt", 32'(gnt), 32'h1);
    tick(); boot_done = 1'b0; #1;
    chk("bd_off_gnt", 32'(gnt), 0);
    tick();
    chk("bd_off_gnt2", 32'(gnt), 0);
    chk("bd_off_rdv", 32'(rd_valid), 32'h1);
    chk("bd_off_rdd", 32'(rd_data), 32'h0001);
    req = '0; boot_done = 1'b1;
    tick();

    // Async reset one cycle after a read grant (rr_ptr = 1, so only port 1 pending would win)
    req = 2'b01; #1;
    chk("ar_gnt", 32'(gnt), 32'h1);
    tick(); req = '0; #1;
    chk("ar_busy_pre", 32'(busy), 1);
    rst = 1'b1; #1;
    chk("ar_busy", 32'(busy), 0);
    chk("ar_rdv", 32'(rd_valid), 0);
    tick();
    chk("ar_rdv_late", 32'(rd_valid), 0);
    rst = 1'b0;
    tick(); set_port(0, 1'b0, 16'h0030, 16'h0); req = 2'b11; #1;
    chk("ar_first_gnt", 32'(gnt), 32'h1);
    tick(); req = '0; #1;
    tick(); tick();

    // mem_we drops asynchronously on reset (rr_ptr = 1)
    set_port(1, 1'b1, 16'h0050, 16'h0055); req = 2'b10; #1;
    chk("arw_gnt", 32'(gnt), 32'h2);
    tick(); req = '0; #1;
    chk("arw_we_pre", 32'(mem_we), 1);
    rst = 1'b1; #1;
    chk("arw_we", 32'(mem_we), 0);
    tick(); rst = 1'b0;
    tick();

    // Idle hold after a write to 0x0040 (rr_ptr = 0)
    set_port(0, 1'b1, 16'h0040, 16'h0077); req = 2'b01; #1;
    chk("idle_gnt", 32'(gnt), 32'h1);
    tick(); req = '0; #1;
    chk("idle_we_pulse", 32'(mem_we), 1);
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("idle_we", 32'(mem_we), 0);
      chk("idle_addr", 32'(mem_addr), 32'h40);
      chk("idle_wd", 32'(mem_wdata), 32'h77);
      chk("idle_gnt0", 32'(gnt), 0);
      chk("idle_rdv", 32'(rd_valid), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
